// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcodes, FSM states,
// accumulator source selects and ALU operation encodings.
package bip_pkg;

   localparam int PC_W     = 11;
   localparam int INSTR_W  = 16;
   localparam int OPCODE_W = 5;

   // Opcode field values (instruction bits [15:11]); 8..31 decode as NOP
   localparam logic [OPCODE_W-1:0] OPC_HLT  = 5'd0;
   localparam logic [OPCODE_W-1:0] OPC_STO  = 5'd1;
   localparam logic [OPCODE_W-1:0] OPC_LD   = 5'd2;
   localparam logic [OPCODE_W-1:0] OPC_LDI  = 5'd3;
   localparam logic [OPCODE_W-1:0] OPC_ADD  = 5'd4;
   localparam logic [OPCODE_W-1:0] OPC_ADDI = 5'd5;
   localparam logic [OPCODE_W-1:0] OPC_SUB  = 5'd6;
   localparam logic [OPCODE_W-1:0] OPC_SUBI = 5'd7;

   // Control FSM states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      DECODE  = 3'd2,
      MEMWAIT = 3'd3,
      HALT    = 3'd4
   } state_t;

   // Accumulator source select
   localparam logic [1:0] SEL_A_MEM = 2'd0;
   localparam logic [1:0] SEL_A_IMM = 2'd1;
   localparam logic [1:0] SEL_A_ALU = 2'd2;

   // ALU operation
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Instructions whose operand is a data-RAM address that must be read
   // before the accumulator can be written.
   function automatic logic needs_mem_read(input logic [OPCODE_W-1:0] opc);
      return (opc == OPC_LD) || (opc == OPC_ADD) || (opc == OPC_SUB);
   endfunction

endpackage

// File: rtl/bip_pc.sv
// Program counter register: async active-low clear, increment enable,
// natural wrap from all-ones back to zero.
module bip_pc #(
   parameter int PC_WIDTH = 11
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   output logic [PC_WIDTH-1:0] pc
);

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   // Advance the program counter when the FSM retires an instruction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= '0;
      end else if (inc) begin
         pc <= pc + PC_ONE;
      end
   end

endmodule

// File: rtl/bip_control.sv
// BIP single-accumulator processor control unit.
// Fetches from a synchronous-read program memory, decodes
// {opcode[15:11], operand[10:0]} and drives the accumulator datapath and
// data-RAM strobes. Optional executed-cycle counter is built when the
// macro BIP_CYCLE_COUNT_EN is defined; otherwise o_clk_count is tied to 0.
module bip_control
   import bip_pkg::*;
#(
   parameter int PC_WIDTH     = 11,
   parameter int INSTR_WIDTH  = 16,
   parameter int OPCODE_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [INSTR_WIDTH-1:0] i_instr,
   output logic [PC_WIDTH-1:0]    o_pc,
   output logic [PC_WIDTH-1:0]    o_operand,
   output logic [1:0]             o_sel_a,
   output logic                   o_sel_b,
   output logic                   o_operation,
   output logic                   o_write_acc,
   output logic                   o_rd_ram,
   output logic                   o_wr_ram,
   output logic                   o_halt,
   output logic                   o_busy,
   output logic [31:0]            o_clk_count
);

   state_t                   state;
   state_t                   state_next;
   logic [INSTR_WIDTH-1:0]   ir;
   logic                     ir_load;
   logic                     pc_inc;
   logic [PC_WIDTH-1:0]      pc;
   logic [OPCODE_WIDTH-1:0]  dec_opc;
   logic [OPCODE_WIDTH-1:0]  ir_opc;

   // Opcode of the word arriving from program memory and of the latched one
   assign dec_opc = i_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
   assign ir_opc  = ir[INSTR_WIDTH-1 -: OPCODE_WIDTH];

   bip_pc #(
      .PC_WIDTH (PC_WIDTH)
   ) u_pc (
      .clk (clk),
      .rst (rst),
      .inc (pc_inc),
      .pc  (pc)
   );

   // FSM state register; reset parks the machine in IDLE so every output
   // decoded from it drops to zero without waiting for a clock edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Instruction register, captured in DECODE for use by MEMWAIT and as the
   // idle-time operand value
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir <= '0;
      end else if (ir_load) begin
         ir <= i_instr;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_next  = state;
      pc_inc      = 1'b0;
      ir_load     = 1'b0;
      o_pc        = pc;
      o_operand   = ir[PC_WIDTH-1:0];
      o_sel_a     = SEL_A_MEM;
      o_sel_b     = 1'b0;
      o_operation = OP_ADD;
      o_write_acc = 1'b0;
      o_rd_ram    = 1'b0;
      o_wr_ram    = 1'b0;
      o_halt      = 1'b0;
      o_busy      = 1'b0;

      case (state)
         IDLE: begin
            o_pc = '0;
            if (i_start) begin
               state_next = FETCH;
            end
         end

         FETCH: begin
            o_busy     = 1'b1;
            state_next = DECODE;
         end

         DECODE: begin
            o_busy    = 1'b1;
            ir_load   = 1'b1;
            // Operand comes straight from memory data so single-cycle ops
            // can act on it in this same cycle
            o_operand = i_instr[PC_WIDTH-1:0];
            if (needs_mem_read(dec_opc)) begin
               // Read the RAM now; accumulator update happens in MEMWAIT
               o_rd_ram   = 1'b1;
               state_next = MEMWAIT;
            end else begin
               case (dec_opc)
                  OPC_HLT: begin
                     state_next = HALT;
                  end
                  OPC_STO: begin
                     o_wr_ram   = 1'b1;
                     pc_inc     = 1'b1;
                     state_next = FETCH;
                  end
                  OPC_LDI: begin
                     o_write_acc = 1'b1;
                     o_sel_a     = SEL_A_IMM;
                     pc_inc      = 1'b1;
                     state_next  = FETCH;
                  end
                  OPC_ADDI: begin
                     o_write_acc = 1'b1;
                     o_sel_a     = SEL_A_ALU;
                     o_sel_b     = 1'b1;
                     o_operation = OP_ADD;
                     pc_inc      = 1'b1;
                     state_next  = FETCH;
                  end
                  OPC_SUBI: begin
                     o_write_acc = 1'b1;
                     o_sel_a     = SEL_A_ALU;
                     o_sel_b     = 1'b1;
                     o_operation = OP_SUB;
                     pc_inc      = 1'b1;
                     state_next  = FETCH;
                  end
                  default: begin
                     // Illegal opcode: skip it like a NOP
                     pc_inc     = 1'b1;
                     state_next = FETCH;
                  end
               endcase
            end
         end

         MEMWAIT: begin
            o_busy      = 1'b1;
            o_write_acc = 1'b1;
            if (ir_opc == OPC_LD) begin
               o_sel_a = SEL_A_MEM;
            end else begin
               o_sel_a     = SEL_A_ALU;
               o_sel_b     = 1'b0;
               o_operation = (ir_opc == OPC_SUB) ? OP_SUB : OP_ADD;
            end
            pc_inc     = 1'b1;
            state_next = FETCH;
         end

         HALT: begin
            // Only reset leaves HALT
            o_halt = 1'b1;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef BIP_CYCLE_COUNT_EN
   logic [31:0] cycle_cnt;

   // Count busy cycles, freezing outside them and saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
      end else if (o_busy && (cycle_cnt != 32'hFFFF_FFFF)) begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   assign o_clk_count = cycle_cnt;
`else
   assign o_clk_count = '0;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control: instruction-level reference model expands each
// program into the expected per-cycle control trace.
module tb_bip_control;

   typedef struct packed {
      logic [10:0] pc;
      logic [10:0] opnd;
      logic [1:0]  sa;
      logic        sb;
      logic        op;
      logic        wa;
      logic        rd;
      logic        wr;
      logic        halt;
      logic        busy;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_instr;
   logic [10:0] o_pc;
   logic [10:0] o_operand;
   logic [1:0]  o_sel_a;
   logic        o_sel_b;
   logic        o_operation;
   logic        o_write_acc;
   logic        o_rd_ram;
   logic        o_wr_ram;
   logic        o_halt;
   logic        o_busy;
   logic [31:0] o_clk_count;

   logic [15:0] mem [0:2047];
   int          checks = 0;
   int          failures = 0;
   rec_t        exp_q[$];
   int          exp_busy;
   rec_t        got;

   bip_control dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_instr     (i_instr),
      .o_pc        (o_pc),
      .o_operand   (o_operand),
      .o_sel_a     (o_sel_a),
      .o_sel_b     (o_sel_b),
      .o_operation (o_operation),
      .o_write_acc (o_write_acc),
      .o_rd_ram    (o_rd_ram),
      .o_wr_ram    (o_wr_ram),
      .o_halt      (o_halt),
      .o_busy      (o_busy),
      .o_clk_count (o_clk_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read program memory
   always @(posedge clk) i_instr <= mem[o_pc];

   assign got = {o_pc, o_operand, o_sel_a, o_sel_b, o_operation,
                 o_write_acc, o_rd_ram, o_wr_ram, o_halt, o_busy};

   function automatic logic [15:0] ins(input int opc, input int a);
      logic [15:0] w;
      w[15:11] = opc[4:0];
      w[10:0]  = a[10:0];
      return w;
   endfunction

   function automatic rec_t mk(input int pc, input logic [10:0] opnd, input int sa,
                               input logic sb, input logic op, input logic wa,
                               input logic rd, input logic wr, input logic halt,
                               input logic busy);
      rec_t r;
      r.pc = pc[10:0]; r.opnd = opnd; r.sa = sa[1:0]; r.sb = sb; r.op = op;
      r.wa = wa; r.rd = rd; r.wr = wr; r.halt = halt; r.busy = busy;
      return r;
   endfunction

   function automatic logic [31:0] cnt_expect(input int busy_cycles);
`ifdef BIP_CYCLE_COUNT_EN
      return busy_cycles;
`else
      return 32'd0;
`endif
   endfunction

   // Instruction-level model: walk the program and list what every cycle
   // should look like, starting at the first FETCH.
   task automatic build_model(input int max_instr, input int n_halt);
      int          pc;
      int          n;
      int          opc;
      bit          halted;
      logic [10:0] ir;
      logic [10:0] a;
      logic [15:0] w;
      pc = 0; n = 0; halted = 0; ir = '0;
      exp_q.delete();
      exp_busy = 0;
      while (!halted && n < max_instr) begin
         w   = mem[pc];
         opc = int'(w[15:11]);
         a   = w[10:0];
         exp_q.push_back(mk(pc, ir, 0, 0, 0, 0, 0, 0, 0, 1));
         ir = a;
         case (opc)
            0: begin exp_q.push_back(mk(pc, a, 0, 0, 0, 0, 0, 0, 0, 1)); halted = 1; end
            1: exp_q.push_back(mk(pc, a, 0, 0, 0, 0, 0, 1, 0, 1));
            3: exp_q.push_back(mk(pc, a, 1, 0, 0, 1, 0, 0, 0, 1));
            5: exp_q.push_back(mk(pc, a, 2, 1, 0, 1, 0, 0, 0, 1));
            7: exp_q.push_back(mk(pc, a, 2, 1, 1, 1, 0, 0, 0, 1));
            2, 4, 6: begin
               exp_q.push_back(mk(pc, a, 0, 0, 0, 0, 1, 0, 0, 1));
               exp_q.push_back(mk(pc, a, (opc == 2) ? 0 : 2, 0, (opc == 6), 1, 0, 0, 0, 1));
            end
            default: exp_q.push_back(mk(pc, a, 0, 0, 0, 0, 0, 0, 0, 1));
         endcase
         if (!halted) pc = (pc + 1) % 2048;
         n++;
      end
      exp_busy = exp_q.size();
      if (halted) begin
         for (int k = 0; k < n_halt; k++) exp_q.push_back(mk(pc, ir, 0, 0, 0, 0, 0, 0, 1, 0));
      end
   endtask

   task automatic clear_mem();
      for (int k = 0; k < 2048; k++) mem[k] = 16'h0000;
   endtask

   task automatic reset_dut();
      i_start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      checks++;
      if (got !== '0 || o_clk_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h cnt=%0d required=0", got, o_clk_count);
      end
      reset_dut();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (got !== '0) begin
            failures++;
            $display("FAIL idle_no_start cyc=%0d got=%h required=0", k, got);
         end
      end
   endtask

   task automatic test_imm_program();
      clear_mem();
      mem[0] = ins(3, 5); mem[1] = ins(5, 3); mem[2] = ins(1, 10); mem[3] = ins(0, 0);
      reset_dut();
      build_model(100, 5);
      @(negedge clk); i_start = 1'b1;
      // i_start stays high throughout, including in HALT
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         checks++;
         if (got !== exp_q[k]) begin
            failures++;
            $display("FAIL imm_prog cyc=%0d got=%h required=%h", k, got, exp_q[k]);
         end
      end
      checks++;
      if (o_clk_count !== cnt_expect(8)) begin
         failures++;
         $display("FAIL imm_prog_count got=%0d required=%0d", o_clk_count, cnt_expect(8));
      end
      i_start = 1'b0;
   endtask

   task automatic test_mem_program();
      clear_mem();
      mem[0] = ins(2, 20); mem[1] = ins(6, 21); mem[2] = ins(4, 22); mem[3] = ins(0, 0);
      reset_dut();
      build_model(100, 2);
      @(negedge clk); i_start = 1'b1;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         i_start = 1'b0;
         checks++;
         if (got !== exp_q[k]) begin
            failures++;
            $display("FAIL mem_prog cyc=%0d got=%h required=%h", k, got, exp_q[k]);
         end
      end
      checks++;
      if (o_clk_count !== cnt_expect(exp_busy)) begin
         failures++;
         $display("FAIL mem_prog_count got=%0d required=%0d", o_clk_count, cnt_expect(exp_busy));
      end
   endtask

   task automatic test_subi_and_illegal();
      clear_mem();
      mem[0] = ins(9, $urandom_range(0, 2047)); mem[1] = ins(7, 11'h7FF); mem[2] = ins(0, 0);
      reset_dut();
      build_model(100, 2);
      @(negedge clk); i_start = 1'b1;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         i_start = 1'b0;
         checks++;
         if (got !== exp_q[k]) begin
            failures++;
            $display("FAIL subi_illegal cyc=%0d got=%h required=%h", k, got, exp_q[k]);
         end
      end
   endtask

   task automatic test_random_programs();
      for (int t = 0; t < 4; t++) begin
         clear_mem();
         for (int k = 0; k < 30; k++) mem[k] = ins($urandom_range(1, 31), $urandom_range(0, 2047));
         mem[30] = ins(0, $urandom_range(0, 2047));
         reset_dut();
         build_model(100, 2);
         @(negedge clk); i_start = 1'b1;
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            i_start = 1'b0;
            checks++;
            if (got !== exp_q[k]) begin
               failures++;
               $display("FAIL random_prog t=%0d cyc=%0d got=%h required=%h", t, k, got, exp_q[k]);
            end
         end
         checks++;
         if (o_clk_count !== cnt_expect(exp_busy)) begin
            failures++;
            $display("FAIL random_count t=%0d got=%0d required=%0d", t, o_clk_count, cnt_expect(exp_busy));
         end
      end
   endtask

   task automatic test_pc_wrap();
      for (int k = 0; k < 2048; k++) mem[k] = ins($urandom_range(1, 31), $urandom_range(0, 2047));
      reset_dut();
      build_model(2051, 0);
      @(negedge clk); i_start = 1'b1;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         i_start = 1'b0;
         checks++;
         if (got !== exp_q[k]) begin
            failures++;
            $display("FAIL pc_wrap cyc=%0d got=%h required=%h", k, got, exp_q[k]);
         end
      end
   endtask

   task automatic test_reset_in_memwait();
      clear_mem();
      mem[0] = ins(2, 20); mem[1] = ins(0, 0);
      reset_dut();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;   // FETCH
      @(negedge clk);                   // DECODE
      @(negedge clk);                   // MEMWAIT
      checks++;
      if (o_write_acc !== 1'b1 || o_operand !== 11'd20) begin
         failures++;
         $display("FAIL memwait_pending wa=%b opnd=%0d required wa=1 opnd=20", o_write_acc, o_operand);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (got !== '0 || o_clk_count !== 32'd0) begin
         failures++;
         $display("FAIL async_reset got=%h cnt=%0d required=0", got, o_clk_count);
      end
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++;
      if (got !== '0) begin
         failures++;
         $display("FAIL after_release got=%h required=0", got);
      end
      i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      checks++;
      if (got !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
         failures++;
         $display("FAIL restart_fetch got=%h required=%h", got, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      end
   endtask

   initial begin
      clear_mem();
      test_reset();
      test_imm_program();
      test_mem_program();
      test_subi_and_illegal();
      test_random_programs();
      test_pc_wrap();
      test_reset_in_memwait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the BIP single-accumulator processor. It is the initiator that drives the accumulator datapath's control inputs (operand, sel_a, sel_b, write_acc, operation).
- Fetches 16-bit instructions from a synchronous-read program memory and decodes {opcode[15:11], operand[10:0]}.
- Sequences the data-RAM read/write strobes and stops in a HALT state.

Parameters:
- PC_WIDTH, 11: program counter and operand width.
- INSTR_WIDTH, 16: instruction word width.
- OPCODE_WIDTH, 5: opcode field width, located at instruction bits [15:11].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  level; starts execution from IDLE.
- i_instr  in  16  program memory read data; valid one cycle after o_pc is presented.
- o_pc  out  11  program memory address.
- o_operand  out  11  to datapath operand input and data-RAM address.
- o_sel_a  out  2  accumulator source: 0 = data RAM, 1 = sign-extended operand, 2 = ALU result.
- o_sel_b  out  1  ALU B input: 1 = sign-extended operand, 0 = data RAM.
- o_operation  out  1  0 = add, 1 = subtract.
- o_write_acc  out  1  accumulator write strobe, one cycle.
- o_rd_ram  out  1  data-RAM read strobe, one cycle.
- o_wr_ram  out  1  data-RAM write strobe, one cycle; write data is the accumulator.
- o_halt  out  1  high while in HALT.
- o_busy  out  1  high in FETCH, DECODE and MEMWAIT.
- o_clk_count  out  32  executed-cycle count (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; pc = 0; instruction register (ir) = 0.
  - All outputs go to 0 immediately, including strobes already asserted mid-instruction.
  - Release of reset is synchronous to clk.
- Opcodes: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7. Opcodes 8–31 are illegal and execute as NOP.
- IDLE: o_pc = 0. When i_start is sampled high, go to FETCH.
- FETCH: o_pc = pc. Go to DECODE unconditionally.
- DECODE: i_instr is valid in this cycle. Load ir <= i_instr. o_operand = i_instr[10:0] (combinational). Action by opcode:
  - HLT: no strobes; go to HALT. pc is not incremented.
  - STO: o_wr_ram = 1; pc++; go to FETCH.
  - LDI: o_write_acc = 1, sel_a = 1; pc++; go to FETCH.
  - ADDI / SUBI: o_write_acc = 1, sel_a = 2, sel_b = 1, operation = 0 / 1; pc++; go to FETCH.
  - LD / ADD / SUB: o_rd_ram = 1; go to MEMWAIT. pc is held.
  - Illegal: no strobes; pc++; go to FETCH.
- MEMWAIT: o_operand = ir[10:0]. Assert o_write_acc for one cycle:
  - LD: sel_a = 0.
  - ADD / SUB: sel_a = 2, sel_b = 0, operation = 0 / 1.
  - Then pc++ and go to FETCH.
- Latency: immediate ops, STO, illegal and HLT take 2 cycles; LD, ADD and SUB take 3 cycles.
- HALT: o_halt = 1 and all strobes 0. i_start is ignored; the state is left only by reset.
- pc wraps 2047 -> 0 with no flag.
- Outside DECODE and MEMWAIT: o_operand = ir[10:0]; sel and operation outputs are 0.
- At most one of o_write_acc, o_rd_ram, o_wr_ram is high in any cycle.
- i_start is only sampled in IDLE.

Optional Feature:
- Macro: BIP_CYCLE_COUNT_EN.
- When defined:
  - A 32-bit counter clears on reset and increments on every cycle in FETCH, DECODE or MEMWAIT.
  - It freezes in HALT and saturates at 0xFFFFFFFF.
  - o_clk_count reflects the counter.
- When undefined: no counter logic; o_clk_count is tied to 0.

Decomposition:
- Package bip_pkg holds:
  - opcode localparams;
  - FSM state encoding (IDLE, FETCH, DECODE, MEMWAIT, HALT);
  - sel_a encodings (SEL_A_MEM, SEL_A_IMM, SEL_A_ALU);
  - operation encodings (OP_ADD, OP_SUB).
- Sub-module bip_pc: PC_WIDTH-bit register with async active-low reset, increment enable and natural wrap.

Test Plan:
- Program {LDI 5, ADDI 3, STO 10, HLT}, start pulsed -> write_acc pulses with sel_a=1 then sel_a=2/sel_b=1/op=0; o_wr_ram high with o_operand=10; o_halt asserted after 8 cycles from FETCH entry; pc frozen at 3.
- Program {LD 20, SUB 21, HLT} with RAM returning data -> o_rd_ram at operand 20, then write_acc with sel_a=0 one cycle later; SUB gives rd_ram then write_acc with sel_a=2, sel_b=0, op=1; 3 cycles per instruction.
- SUBI with operand 0x7FF (-1) -> o_operand=0x7FF, sel_b=1, op=1, single write_acc pulse.
- Opcode 9 at pc 0 followed by HLT -> no strobes during opcode 9; pc advances to 1; halts at pc 1.
- Program filling to address 2047 with no HLT -> pc wraps to 0 and execution continues.
- rst asserted while in MEMWAIT with o_write_acc pending -> all outputs 0 without waiting for clk; after release, IDLE with pc=0; i_start held high in HALT has no effect. With BIP_CYCLE_COUNT_EN defined, o_clk_count=8 after the first program.
